iir_unfold2_q: RTL and testbench

// - Parametrised successor to the team's 2-unfolded 2nd-order IIR: y(n)=a*x(n)+b*x(n-1)+c*y(n-1)+d*y(n-2).
// - Consumes two samples per clock, x(2k) and x(2k+1); produces y(2k) and y(2k+1) with one cycle of latency.
// - Adds signed Q-format arithmetic, saturation, a valid handshake with stall, runtime coefficient load
//   and a sticky overflow flag. Sits between the sample deserialiser and the output formatter.

---
 rtl/iir_pkg.sv | 25 ++
 rtl/iir_mac4_q.sv | 47 ++++
 rtl/iir_unfold2_q.sv | 116 +++++++++++
 tb/tb_iir_unfold2_q.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, rounding constant and saturating narrow for the unfolded IIR
package iir_pkg;

  // Accumulator width: two guard bits above a full W x CW product cover the four-term sum
  function automatic int acc_w(input int w, input int cw);
    return w + cw + 2;
  endfunction

  // Half an LSB of the output, added before the shift when rounding is enabled
  function automatic logic signed [63:0] rnd(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

  // Clamp a sign-extended value into the signed w-bit range
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] acc, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/iir_mac4_q.sv
// rtl/iir_mac4_q.sv - four-term signed MAC with shift, optional rounding (IIR_ROUND_EN) and saturation
module iir_mac4_q
  import iir_pkg::*;
#(
  parameter int W    = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic signed [W-1:0]  s0,
  input  logic signed [W-1:0]  s1,
  input  logic signed [W-1:0]  s2,
  input  logic signed [W-1:0]  s3,
  input  logic signed [CW-1:0] k0,
  input  logic signed [CW-1:0] k1,
  input  logic signed [CW-1:0] k2,
  input  logic signed [CW-1:0] k3,
  output logic signed [W-1:0]  y,
  output logic                 sat
);

  localparam int PW    = W + CW;
  localparam int ACC_W = acc_w(W, CW);

  logic signed [PW-1:0]    p0, p1, p2, p3;
  logic signed [ACC_W-1:0] acc_sum, acc_rnd, shifted;
  logic signed [63:0]      wide, clamped;

  // Full-precision products, sum, quantise to the output grid, then clamp (ACC_W must stay <= 64)
  always_comb begin
    p0      = PW'(s0) * PW'(k0);
    p1      = PW'(s1) * PW'(k1);
    p2      = PW'(s2) * PW'(k2);
    p3      = PW'(s3) * PW'(k3);
    acc_sum = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2) + ACC_W'(p3);
`ifdef IIR_ROUND_EN
    acc_rnd = acc_sum + ACC_W'(rnd(FRAC));
`else
    acc_rnd = acc_sum;
`endif
    shifted = acc_rnd >>> FRAC;
    wide    = 64'(shifted);
    clamped = sat_w(wide, W);
    y       = clamped[W-1:0];
    sat     = (clamped != wide);
  end

endmodule

// File: rtl/iir_unfold2_q.sv
// rtl/iir_unfold2_q.sv - 2-unfolded 2nd-order Q-format IIR with handshake, coefficient load and clear (IIR_ROUND_EN)
module iir_unfold2_q
  import iir_pkg::*;
#(
  parameter int W    = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 coef_load,
  input  logic signed [CW-1:0] coef_a,
  input  logic signed [CW-1:0] coef_b,
  input  logic signed [CW-1:0] coef_c,
  input  logic signed [CW-1:0] coef_d,
  input  logic                 in_valid,
  input  logic signed [W-1:0]  x0,
  input  logic signed [W-1:0]  x1,
  output logic                 out_valid,
  output logic signed [W-1:0]  y0,
  output logic signed [W-1:0]  y1,
  output logic                 sat_flag
);

  logic signed [CW-1:0] ca_q, cb_q, cc_q, cd_q, ca_d, cb_d, cc_d, cd_d;
  logic signed [W-1:0]  xh1_q, yh1_q, yh2_q, xh1_d, yh1_d, yh2_d;
  logic signed [W-1:0]  y0_q, y1_q, y0_d, y1_d;
  logic                 out_valid_q, out_valid_d, sat_q, sat_d;
  logic signed [W-1:0]  y0_c, y1_c;
  logic                 sat0_c, sat1_c;

  // y(2k) from the stored history
  iir_mac4_q #(.W(W), .CW(CW), .FRAC(FRAC)) u_mac_y0 (
    .s0(x0), .s1(xh1_q), .s2(yh1_q), .s3(yh2_q),
    .k0(ca_q), .k1(cb_q), .k2(cc_q), .k3(cd_q),
    .y(y0_c), .sat(sat0_c)
  );

  // y(2k+1) chains off the already quantised and clamped y(2k)
  iir_mac4_q #(.W(W), .CW(CW), .FRAC(FRAC)) u_mac_y1 (
    .s0(x1), .s1(x0), .s2(y0_c), .s3(yh1_q),
    .k0(ca_q), .k1(cb_q), .k2(cc_q), .k3(cd_q),
    .y(y1_c), .sat(sat1_c)
  );

  // Next state: coefficient shadowing, then clear beats an accepted pair, otherwise hold
  always_comb begin
    ca_d        = ca_q;
    cb_d        = cb_q;
    cc_d        = cc_q;
    cd_d        = cd_q;
    xh1_d       = xh1_q;
    yh1_d       = yh1_q;
    yh2_d       = yh2_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    if (coef_load) begin
      ca_d = coef_a;
      cb_d = coef_b;
      cc_d = coef_c;
      cd_d = coef_d;
    end
    if (clear) begin
      xh1_d = '0;
      yh1_d = '0;
      yh2_d = '0;
      sat_d = 1'b0;
    end else if (in_valid) begin
      y0_d        = y0_c;
      y1_d        = y1_c;
      xh1_d       = x1;
      yh1_d       = y1_c;
      yh2_d       = y0_c;
      out_valid_d = 1'b1;
      sat_d       = sat_q | sat0_c | sat1_c;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ca_q        <= '0;
      cb_q        <= '0;
      cc_q        <= '0;
      cd_q        <= '0;
      xh1_q       <= '0;
      yh1_q       <= '0;
      yh2_q       <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      ca_q        <= ca_d;
      cb_q        <= cb_d;
      cc_q        <= cc_d;
      cd_q        <= cd_d;
      xh1_q       <= xh1_d;
      yh1_q       <= yh1_d;
      yh2_q       <= yh2_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign y0        = y0_q;
  assign y1        = y1_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_unfold2_q.sv
// tb/tb_iir_unfold2_q.sv - self-checking bench for iir_unfold2_q with a per-sample reference model
module tb_iir_unfold2_q;

  localparam int W    = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;
`ifdef IIR_ROUND_EN
  localparam int RND_POS = 2;
  localparam int RND_NEG = -1;
`else
  localparam int RND_POS = 1;
  localparam int RND_NEG = -2;
`endif

  logic clk = 1'b0;
  logic rst, clear, coef_load, in_valid;
  logic signed [CW-1:0] coef_a, coef_b, coef_c, coef_d;
  logic signed [W-1:0]  x0, x1, y0, y1;
  logic out_valid, sat_flag;

  int checks = 0;
  int errors = 0;

  // Reference model state: one sample at a time, y(n)=a x(n)+b x(n-1)+c y(n-1)+d y(n-2)
  longint ma, mb, mc, md;
  longint m_xp, m_yp1, m_yp2;
  longint m_y0, m_y1;
  bit     m_ov, m_sat;

  iir_unfold2_q #(.W(W), .CW(CW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .clear(clear), .coef_load(coef_load),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
    .in_valid(in_valid), .x0(x0), .x1(x1),
    .out_valid(out_valid), .y0(y0), .y1(y1), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic void ref_sample(input longint xn, input longint xprev, output longint yn, output bit s);
    longint acc;
    acc = ma * xn + mb * xprev + mc * m_yp1 + md * m_yp2;
`ifdef IIR_ROUND_EN
    acc = acc + (longint'(1) <<< (FRAC - 1));
`endif
    acc = acc >>> FRAC;
    s = 1'b0;
    if (acc > 32767) begin acc = 32767; s = 1'b1; end
    if (acc < -32768) begin acc = -32768; s = 1'b1; end
    yn = acc;
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; mc = 0; md = 0;
    m_xp = 0; m_yp1 = 0; m_yp2 = 0;
    m_y0 = 0; m_y1 = 0; m_ov = 0; m_sat = 0;
  endtask

  task automatic model_update(input bit v, input longint a0, input longint a1, input bit ld, input bit clr);
    longint ya, yb;
    bit sa, sb;
    if (clr) begin
      m_xp = 0; m_yp1 = 0; m_yp2 = 0; m_sat = 0; m_ov = 0;
    end else if (v) begin
      ref_sample(a0, m_xp, ya, sa);
      m_yp2 = m_yp1; m_yp1 = ya;
      ref_sample(a1, a0, yb, sb);
      m_yp2 = m_yp1; m_yp1 = yb;
      m_xp = a1;
      m_y0 = ya; m_y1 = yb; m_ov = 1;
      m_sat = m_sat | sa | sb;
    end else begin
      m_ov = 0;
    end
    if (ld) begin
      ma = coef_a; mb = coef_b; mc = coef_c; md = coef_d;
    end
  endtask

  task automatic step(input bit v, input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                      input bit ld, input bit clr);
    in_valid = v; x0 = a0; x1 = a1; coef_load = ld; clear = clr;
    model_update(v, longint'(a0), longint'(a1), ld, clr);
    @(posedge clk); #1;
    in_valid = 0; coef_load = 0; clear = 0;
  endtask

  task automatic set_coefs(input int a, input int b, input int c, input int d, input bit clr);
    coef_a = CW'(a); coef_b = CW'(b); coef_c = CW'(c); coef_d = CW'(d);
    step(0, 0, 0, 1, clr);
  endtask

  task automatic test_reset();
    rst = 1; clear = 0; coef_load = 0; in_valid = 0; x0 = 0; x1 = 0;
    coef_a = 0; coef_b = 0; coef_c = 0; coef_d = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checks++; if (y0 !== 16'sd0) begin errors++; $display("FAIL reset_y0: got %0d want 0", y0); end
    checks++; if (y1 !== 16'sd0) begin errors++; $display("FAIL reset_y1: got %0d want 0", y1); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_pass_through();
    set_coefs(16384, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_idle_valid: got %b want 0", out_valid); end
    step(1, 1000, 2000, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b want 1", out_valid); end
    checks++; if (y0 !== 16'sd1000) begin errors++; $display("FAIL pass_y0: got %0d want 1000", y0); end
    checks++; if (y1 !== 16'sd2000) begin errors++; $display("FAIL pass_y1: got %0d want 2000", y1); end
  endtask

  task automatic test_delay();
    set_coefs(0, 16384, 0, 0, 1);
    step(1, 100, 200, 0, 0);
    step(1, 300, 400, 0, 0);
    checks++; if (y0 !== 16'sd200) begin errors++; $display("FAIL delay_y0: got %0d want 200", y0); end
    checks++; if (y1 !== 16'sd300) begin errors++; $display("FAIL delay_y1: got %0d want 300", y1); end
  endtask

  task automatic test_feedback();
    set_coefs(16384, 0, 8192, 0, 1);
    step(1, 4096, 0, 0, 0);
    checks++; if (y0 !== 16'sd4096 || y1 !== 16'sd2048) begin
      errors++; $display("FAIL feedback_first: got (%0d,%0d) want (4096,2048)", y0, y1); end
    step(1, 0, 0, 0, 0);
    checks++; if (y0 !== 16'sd1024 || y1 !== 16'sd512) begin
      errors++; $display("FAIL feedback_second: got (%0d,%0d) want (1024,512)", y0, y1); end
  endtask

  task automatic test_saturation();
    set_coefs(16384, 0, 16384, 0, 1);
    step(1, 20000, 20000, 0, 0);
    checks++; if (y0 !== 16'sd20000) begin errors++; $display("FAIL sat_y0: got %0d want 20000", y0); end
    checks++; if (y1 !== 16'sd32767) begin errors++; $display("FAIL sat_y1: got %0d want 32767", y1); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
    step(1, 20000, 20000, 0, 0);
    checks++; if (y0 !== 16'sd32767) begin errors++; $display("FAIL sat_y0_second: got %0d want 32767", y0); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_sticky: got %b want 1", sat_flag); end
    step(1, 5, 5, 0, 1);
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_drops_pair: got %b want 0", out_valid); end
    checks++; if (y1 !== 16'sd32767) begin errors++; $display("FAIL clear_holds_y1: got %0d want 32767", y1); end
  endtask

  task automatic test_coef_reload();
    set_coefs(16384, 0, 0, 0, 1);
    coef_a = 16'sd8192;
    step(1, 500, 600, 1, 0);
    checks++; if (y0 !== 16'sd500 || y1 !== 16'sd600) begin
      errors++; $display("FAIL reload_old_set: got (%0d,%0d) want (500,600)", y0, y1); end
    step(1, 500, 600, 0, 0);
    checks++; if (y0 !== 16'sd250 || y1 !== 16'sd300) begin
      errors++; $display("FAIL reload_new_set: got (%0d,%0d) want (250,300)", y0, y1); end
  endtask

  task automatic test_rounding();
    set_coefs(8192, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0);
    checks++; if (y0 !== W'(RND_POS)) begin errors++; $display("FAIL round_pos: got %0d want %0d", y0, RND_POS); end
    step(1, -3, 0, 0, 0);
    checks++; if (y0 !== W'(RND_NEG)) begin errors++; $display("FAIL round_neg: got %0d want %0d", y0, RND_NEG); end
  endtask

  task automatic test_stall();
    logic signed [W-1:0] px0 [4];
    logic signed [W-1:0] px1 [4];
    logic signed [W-1:0] r0 [4];
    logic signed [W-1:0] r1 [4];
    for (int i = 0; i < 4; i++) begin
      px0[i] = W'($urandom_range(0, 8000)) - 16'sd4000;
      px1[i] = W'($urandom_range(0, 8000)) - 16'sd4000;
    end
    set_coefs(16384, 4096, 4096, -2048, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, px0[i], px1[i], 0, 0);
      r0[i] = y0; r1[i] = y1;
    end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, px0[i], px1[i], 0, 0);
      checks++; if (y0 !== r0[i] || y1 !== r1[i]) begin
        errors++; $display("FAIL stall_pair%0d: got (%0d,%0d) want (%0d,%0d)", i, y0, y1, r0[i], r1[i]); end
      for (int j = 0; j < 3; j++) begin
        step(0, 16'sd1234, 16'sd777, 0, 0);
        checks++; if (out_valid !== 1'b0 || y0 !== r0[i]) begin
          errors++; $display("FAIL stall_idle%0d: got valid=%b y0=%0d want valid=0 y0=%0d", i, out_valid, y0, r0[i]); end
      end
    end
  endtask

  task automatic test_rst_mid();
    set_coefs(16384, 0, 8192, 0, 1);
    step(1, 4096, 0, 0, 0);
    rst = 1;
    #1;
    checks++; if (y0 !== 16'sd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async: got y0=%0d valid=%b want 0,0", y0, out_valid); end
    model_reset();
    @(posedge clk); #1 rst = 0;
    set_coefs(16384, 0, 8192, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++; if (y0 !== 16'sd0 || y1 !== 16'sd0) begin
      errors++; $display("FAIL rst_history: got (%0d,%0d) want (0,0)", y0, y1); end
  endtask

  task automatic test_random();
    bit v, ld, clr;
    logic signed [W-1:0] a0, a1;
    step(0, 0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      if (ld) begin
        coef_a = CW'($urandom_range(0, 32767)) - 16'sd16384;
        coef_b = CW'($urandom_range(0, 16383)) - 16'sd8192;
        coef_c = CW'($urandom_range(0, 16383)) - 16'sd8192;
        coef_d = CW'($urandom_range(0, 8191)) - 16'sd4096;
      end
      a0 = W'($urandom);
      a1 = W'($urandom);
      step(v, a0, a1, ld, clr);
      checks++; if (out_valid !== m_ov) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, m_ov); end
      checks++; if (y0 !== W'(m_y0) || y1 !== W'(m_y1)) begin
        errors++; $display("FAIL rand_y[%0d]: got (%0d,%0d) want (%0d,%0d)", n, y0, y1, m_y0, m_y1); end
      checks++; if (sat_flag !== m_sat) begin
        errors++; $display("FAIL rand_sat[%0d]: got %b want %b", n, sat_flag, m_sat); end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_delay();
    test_feedback();
    test_saturation();
    test_coef_reload();
    test_rounding();
    test_stall();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
